// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding request/grant/response imem master
// feeding a small instruction queue toward IF/ID, with redirect flush and stale-response drop.
module ifu_fetch #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 64'h8000_0000,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_fault
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  fault;
  } entry_t;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    fetch_pc, req_pc;
  logic                     drop;
  entry_t [QUEUE_DEPTH-1:0] queue;
  logic [PTR_W-1:0]         head, tail;
  logic [CNT_W-1:0]         count;
  logic                     issue, rsp, push, pop;
  entry_t                   head_entry, push_entry;

  assign issue     = !rst && state == IDLE && !redirect_valid && count < CNT_W'(QUEUE_DEPTH);
  assign imem_req  = issue || state == REQ;
  // A request waiting for grant keeps its original address even across a redirect.
  assign imem_addr = (state == REQ) ? req_pc : fetch_pc;

  assign rsp        = state == WAIT && imem_rvalid;
  assign push       = rsp && !drop && !redirect_valid;
  assign push_entry = '{pc: fetch_pc, inst: imem_err ? NOP : imem_rdata, fault: imem_err};

  assign out_valid  = count != '0 && !redirect_valid;
  assign pop        = out_valid && out_ready;
  assign head_entry = queue[head];
  assign out_pc     = head_entry.pc;
  assign out_inst   = head_entry.inst;
  assign out_fault  = head_entry.fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue[i] <= '{pc: '0, inst: NOP, fault: 1'b0};
    end else begin
      unique case (state)
        IDLE: if (issue) begin
          req_pc <= fetch_pc;
          state  <= imem_gnt ? WAIT : REQ;
        end
        REQ:     if (imem_gnt) state <= WAIT;
        WAIT:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A redirect with a request pending or in flight poisons that request's response.
      if (rsp) drop <= 1'b0;
      else if (redirect_valid && state != IDLE) drop <= 1'b1;

      if (redirect_valid) fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (push) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);

      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          queue[tail] <= push_entry;
          tail        <= tail + PTR_W'(1);
        end
        if (pop) head <= head + PTR_W'(1);
        if (push && !pop) count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural imem responder with programmable latencies and a
// program-order scoreboard predicting every delivered {pc, inst, fault}.
module tb_ifu_fetch;
  localparam int AW = 64, IW = 32, DEPTH = 2;
  localparam logic [AW-1:0] RST_PC = 64'h8000_0000;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [AW-1:0] imem_addr, redirect_pc, out_pc;
  logic [IW-1:0] imem_rdata, out_inst;
  logic          redirect_valid, out_valid, out_ready, out_fault;

  ifu_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  // memory knobs and state
  int            g_dly = 0, r_dly = 1, wait_cnt = 0, rcnt = 0, cur_gd = 0, cur_rd = 1;
  bit            rand_mode = 0, err_rand = 0, busy = 0, waiting = 0, fresh = 0, pend = 0;
  logic [AW-1:0] err_addr = 64'h1, maddr = '0, pend_addr = '0, s_addr = '0;
  logic          s_req = 1'b0, s_gnt = 1'b0;
  // scoreboard
  logic [AW-1:0] exp_pc = RST_PC;
  int            issued = 0, popped = 0;
  logic [AW-1:0] req_log[$], pop_pc[$];
  logic [IW-1:0] pop_inst[$];
  logic          pop_fault[$];
  int            pop_cyc[$];

  function automatic logic [IW-1:0] inst_fn(logic [AW-1:0] a);
    return a[31:0] ^ 32'hA5A5_A5A5;
  endfunction
  function automatic logic err_fn(logic [AW-1:0] a);
    return (a == err_addr) || (err_rand && a[5:2] == 4'hB);
  endfunction
  function automatic logic [AW-1:0] lg(int i);
    return (i < req_log.size()) ? req_log[i] : '1;
  endfunction
  function automatic logic [AW-1:0] pp(int i);
    return (i < pop_pc.size()) ? pop_pc[i] : '1;
  endfunction

  task automatic chk(string tag, logic [AW-1:0] got, logic [AW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mem_drive();
    imem_rvalid = busy && rcnt == 0;
    imem_rdata  = imem_rvalid ? inst_fn(maddr) : IW'($urandom);
    imem_err    = imem_rvalid ? err_fn(maddr) : ($urandom_range(0, 1) == 1);
    fresh = 0;
    if (imem_req && !busy && !waiting) begin
      fresh = 1; waiting = 1; wait_cnt = 0;
      cur_gd = rand_mode ? int'($urandom_range(0, 2)) : g_dly;
      cur_rd = rand_mode ? int'($urandom_range(1, 3)) : r_dly;
    end
    imem_gnt = imem_req && waiting && wait_cnt == cur_gd;
  endtask

  task automatic monitor();
    s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt;
    if (rst) return;
    if (busy) chk("single_outstanding", 64'(imem_req), 0);
    if (pend) begin
      chk("req_hold", 64'(imem_req), 1);
      chk("addr_hold", imem_addr, pend_addr);
    end
    if (fresh) begin
      req_log.push_back(imem_addr);
      chk("addr_align", 64'(imem_addr[1:0]), 0);
      issued++;
      chk("occupancy", 64'((issued - popped) <= DEPTH), 1);
    end
    if (redirect_valid) begin
      chk("valid_on_redirect", 64'(out_valid), 0);
      exp_pc = {redirect_pc[AW-1:2], 2'b00};
      issued = 0; popped = 0;
    end else if (out_valid && out_ready) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_inst", 64'(out_inst), 64'(err_fn(exp_pc) ? NOP : inst_fn(exp_pc)));
      chk("out_fault", 64'(out_fault), 64'(err_fn(exp_pc)));
      pop_pc.push_back(out_pc); pop_inst.push_back(out_inst);
      pop_fault.push_back(out_fault); pop_cyc.push_back(cyc);
      popped++;
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic mem_update();
    if (rst) begin
      busy = 0; waiting = 0; pend = 0; exp_pc = RST_PC; issued = 0; popped = 0;
      return;
    end
    if (busy) begin
      if (rcnt == 0) busy = 0;
      else rcnt--;
    end
    if (s_gnt) begin
      busy = 1; waiting = 0; maddr = s_addr; rcnt = cur_rd - 1;
    end else if (waiting) wait_cnt++;
    pend = s_req && !s_gnt;
    pend_addr = s_addr;
  endtask

  task automatic tick();
    #1; mem_drive();
    #1; monitor();
    @(posedge clk); mem_update(); cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; redirect_valid = 0;
    tick(); tick();
    rst = 0;
    req_log.delete(); pop_pc.delete(); pop_inst.delete(); pop_fault.delete(); pop_cyc.delete();
  endtask

  initial begin
    int n0;
    rst = 1; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; imem_err = 0;
    @(negedge clk);

    // reset values while rst is held
    tick(); tick();
    #1;
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", 64'(out_inst), 64'(NOP));
    chk("rst_fault", 64'(out_fault), 0);

    // zero-wait memory, always ready
    out_ready = 1; g_dly = 0; r_dly = 1;
    do_reset();
    repeat (8) tick();
    chk("t1_req0", lg(0), RST_PC);
    chk("t1_pop0", pp(0), RST_PC);
    chk("t1_pop1", pp(1), RST_PC + 64'd4);
    chk("t1_pop2", pp(2), RST_PC + 64'd8);
    chk("t1_npop", 64'(pop_pc.size() >= 3), 1);
    if (pop_cyc.size() >= 3) begin
      chk("t1_gap01", 64'(pop_cyc[1] - pop_cyc[0]), 2);
      chk("t1_gap12", 64'(pop_cyc[2] - pop_cyc[1]), 2);
    end

    // backpressure fills the queue, then drains in order
    out_ready = 0;
    do_reset();
    repeat (10) tick();
    chk("t2_nreq", 64'(req_log.size()), 2);
    chk("t2_req0", lg(0), RST_PC);
    chk("t2_req1", lg(1), RST_PC + 64'd4);
    #1; chk("t2_req_idle", 64'(imem_req), 0);
    out_ready = 1;
    repeat (6) tick();
    chk("t2_pop0", pp(0), RST_PC);
    chk("t2_pop1", pp(1), RST_PC + 64'd4);
    chk("t2_resume", lg(2), RST_PC + 64'd8);

    // redirect while waiting on a slow response
    r_dly = 4;
    do_reset();
    tick();
    redirect_valid = 1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 0;
    repeat (3) tick();
    #1;
    chk("t3_empty", 64'(out_valid), 0);
    chk("t3_req", 64'(imem_req), 1);
    chk("t3_addr", imem_addr, 64'h8000_0100);
    repeat (12) tick();
    chk("t3_pop0", pp(0), 64'h8000_0100);
    chk("t3_req1", lg(1), 64'h8000_0100);

    // redirect in the same cycle as rvalid, with an entry already queued
    r_dly = 1; out_ready = 0;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1; redirect_pc = 64'h8000_1000;
    #1; chk("t4_valid_masked", 64'(out_valid), 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("t4_flushed", 64'(out_valid), 0);
    chk("t4_req", 64'(imem_req), 1);
    chk("t4_addr", imem_addr, 64'h8000_1000);
    out_ready = 1;
    repeat (8) tick();
    chk("t4_pop0", pp(0), 64'h8000_1000);

    // grant withheld for 4 cycles, redirect in the third
    g_dly = 4;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1; redirect_pc = 64'h8000_2000;
    #1;
    chk("t5_req_held", 64'(imem_req), 1);
    chk("t5_addr_held", imem_addr, RST_PC);
    tick();
    redirect_valid = 0;
    #1;
    chk("t5_req_c3", 64'(imem_req), 1);
    chk("t5_addr_c3", imem_addr, RST_PC);
    repeat (20) tick();
    chk("t5_req1", lg(1), 64'h8000_2000);
    chk("t5_pop0", pp(0), 64'h8000_2000);

    // bus error on the third fetch
    g_dly = 0; err_addr = 64'h8000_0008;
    do_reset();
    repeat (12) tick();
    chk("t6_fault", 64'(pop_fault.size() > 2 ? pop_fault[2] : 1'b0), 1);
    chk("t6_inst", 64'(pop_inst.size() > 2 ? pop_inst[2] : '0), 64'(NOP));
    chk("t6_next", lg(3), 64'h8000_000C);
    err_addr = 64'h1;

    // randomized traffic: latencies, backpressure, redirects (incl. near address wrap), resets
    rand_mode = 1; err_rand = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      rst            = ($urandom_range(0, 499) == 0);
      redirect_valid = !rst && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      else redirect_pc = {$urandom, $urandom};
      tick();
    end
    rst = 0;

    // drain with a clean memory to confirm forward progress
    rand_mode = 0; g_dly = 0; r_dly = 1; err_rand = 0; out_ready = 1;
    redirect_valid = 1; redirect_pc = 64'h8000_4000;
    tick();
    redirect_valid = 0;
    n0 = pop_pc.size();
    repeat (30) tick();
    chk("drain_progress", 64'(pop_pc.size() >= n0 + 5), 1);
    chk("drain_first", pp(n0), 64'h8000_4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
